// File: rtl/mem_dump_tx.sv
// mem_dump_tx
//
// Streams a range of data-memory words out of a UART transmitter (8N1,
// LSB first, idle high).  Each word is LANES bytes wide and goes out as
// LANES back-to-back frames, lane 0 first.  A dump covers the word
// addresses first_addr..last_addr inclusive.
//
// Ports
//   clock       single clock, rising edge
//   rst         synchronous active-high reset (has priority over start)
//   start       begin a dump; only looked at while idle
//   first_addr  first word address, captured when start is accepted
//   last_addr   last word address (inclusive), captured with first_addr
//   mem_addr    registered read address to the shared data memory
//   mem_q       read data; lane k is bits [8k+7:8k]
//   uart_tx     serial output
//   busy        high whenever a dump is in progress
//   done        one-cycle pulse in the first idle cycle after a dump
//   range_err   one-cycle pulse when a start is refused (last < first)
//
// Per word the sequence is: RD_ADDR, RD_WAIT, then LANES frames of
// 10*CLKS_PER_BIT cycles, then one NEXT cycle.  The memory is allowed two
// edges of read latency after mem_addr changes.
module mem_dump_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int LANES        = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          first_addr,
    input  logic [15:0]          last_addr,
    output logic [15:0]          mem_addr,
    input  logic [8*LANES-1:0]   mem_q,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 done,
    output logic                 range_err
);

    localparam int              LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [9:0]      BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]   LANE_LAST = LW'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT
    } state_t;

    state_t               state;
    logic [15:0]          last_q;    // latched end address of the dump
    logic [8*LANES-1:0]   word_q;    // current word; lane being sent sits in [7:0]
    logic [7:0]           byte_sr;   // remaining data bits of the current frame
    logic [LW-1:0]        lane;
    logic [2:0]           bit_idx;
    logic [9:0]           bit_cnt;   // cycles within the current bit
    logic                 bit_end;

    // The counter restarts from zero at every bit boundary, so the bit
    // period never accumulates error across a long dump.
    assign bit_end = (bit_cnt == BIT_LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= 16'h0000;
            last_q    <= 16'h0000;
            word_q    <= '0;
            byte_sr   <= 8'h00;
            lane      <= '0;
            bit_idx   <= 3'd0;
            bit_cnt   <= 10'd0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            range_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (last_addr >= first_addr) begin
                            // mem_addr doubles as the captured first address.
                            mem_addr <= first_addr;
                            last_q   <= last_addr;
                            busy     <= 1'b1;
                            state    <= RD_ADDR;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    // Two edges after the address update: read data is valid.
                    word_q  <= mem_q;
                    lane    <= '0;
                    bit_cnt <= 10'd0;
                    uart_tx <= 1'b0;
                    state   <= START_BIT;
                end

                START_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= 10'd0;
                        bit_idx <= 3'd0;
                        uart_tx <= word_q[0];
                        byte_sr <= {1'b0, word_q[7:1]};
                        state   <= DATA_BITS;
                    end else begin
                        bit_cnt <= bit_cnt + 10'd1;
                    end
                end

                DATA_BITS: begin
                    if (bit_end) begin
                        bit_cnt <= 10'd0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= byte_sr[0];
                            byte_sr <= byte_sr >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 10'd1;
                    end
                end

                STOP_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= 10'd0;
                        if (lane != LANE_LAST) begin
                            // Next lane follows immediately: no idle gap.
                            lane    <= lane + 1'b1;
                            word_q  <= word_q >> 8;
                            uart_tx <= 1'b0;
                            state   <= START_BIT;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 10'd1;
                    end
                end

                NEXT: begin
                    // Compare before incrementing so a dump ending at 0xFFFF
                    // stops there instead of wrapping to 0x0000.
                    if (mem_addr == last_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mem_addr <= mem_addr + 16'd1;
                        state    <= RD_ADDR;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: memory model, UART receiver and a byte-stream
// reference built directly from the memory contents and address range.
module tb_mem_dump_tx;

    localparam int CPB   = 4;
    localparam int LANES = 4;
    localparam int WORD_CYC = 3 + LANES * 10 * CPB;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       first_addr = 16'h0000;
    logic [15:0]       last_addr = 16'h0000;
    logic [15:0]       mem_addr;
    logic [8*LANES-1:0] mem_q = '0;
    logic              uart_tx;
    logic              busy;
    logic              done;
    logic              range_err;

    mem_dump_tx #(.CLKS_PER_BIT(CPB), .LANES(LANES)) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .done       (done),
        .range_err  (range_err)
    );

    always #5 clock = ~clock;

    // Synchronous-read data memory.
    logic [31:0] mem [0:65535];
    always @(posedge clock) mem_q <= mem[mem_addr];

    // Scoreboard state.
    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    int          rx_bad = 0;
    int          cyc_g = 0;
    logic [15:0] addr_seq[$];
    int n_cyc, n_done, n_busy_bad, n_addr_bad;

    // UART receiver: samples mid-bit, on the falling clock edge.
    int          rx_ph = 0;
    bit          rx_act = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    always @(negedge clock) begin
        cyc_g++;
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 0;
                rx_t.push_back(cyc_g);
            end
        end else begin
            rx_ph++;
            if (rx_ph == CPB / 2 && uart_tx !== 1'b0) rx_bad++;
            if (rx_ph >= CPB + CPB / 2 && rx_ph < 9 * CPB && ((rx_ph - CPB / 2) % CPB) == 0)
                rx_byte = {uart_tx, rx_byte[7:1]};
            if (rx_ph == 9 * CPB + CPB / 2) begin
                if (uart_tx !== 1'b1) rx_bad++;
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush_rx();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        rx_bad = 0;
    endtask

    // Expected byte stream: every word in the range, lanes low to high.
    task automatic build_exp(input logic [15:0] f, input logic [15:0] l);
        logic [31:0] w;
        for (int a = int'(f); a <= int'(l); a++) begin
            w = mem[a];
            for (int k = 0; k < LANES; k++) exp_q.push_back(w[8*k +: 8]);
        end
    endtask

    task automatic check_rx(input string tag, input bit gaps);
        int mism = 0, gap_bad = 0, want;
        chk({tag, "_frames"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) mism++;
        chk({tag, "_bytes_bad"}, mism, 0);
        if (gaps) begin
            for (int i = 1; i < rx_t.size(); i++) begin
                want = (i % LANES == 0) ? 10 * CPB + 3 : 10 * CPB;
                if (rx_t[i] - rx_t[i-1] != want) gap_bad++;
            end
            chk({tag, "_frame_spacing_bad"}, gap_bad, 0);
        end
        chk({tag, "_framing_bad"}, rx_bad, 0);
    endtask

    // Called just after a rising edge.  Drives start and waits for done;
    // while busy, start/addresses are scrambled unless hold is set.
    task automatic run_dump(input logic [15:0] f, input logic [15:0] l, input bit hold);
        build_exp(f, l);
        n_cyc = 0; n_done = 0; n_busy_bad = 0; n_addr_bad = 0;
        addr_seq.delete();
        first_addr = f; last_addr = l; start = 1'b1;
        while (n_done == 0 && n_cyc < 20000) begin
            @(posedge clock); #1;
            n_cyc++;
            if (done === 1'b1) n_done++;
            else begin
                if (busy !== 1'b1) n_busy_bad++;
                if (mem_addr < f || mem_addr > l) n_addr_bad++;
                if (addr_seq.size() == 0 || addr_seq[$] !== mem_addr) addr_seq.push_back(mem_addr);
                if (!hold) begin
                    start      = ($urandom_range(0, 5) == 0);
                    first_addr = 16'($urandom);
                    last_addr  = 16'($urandom);
                end
            end
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic dump_checks(input string tag, input logic [15:0] f, input logic [15:0] l);
        int n = int'(l) - int'(f) + 1;
        int step_bad = 0;
        chk({tag, "_cycles"}, n_cyc, n * WORD_CYC + 1);
        chk({tag, "_done_seen"}, n_done, 1);
        chk({tag, "_busy_gap"}, n_busy_bad, 0);
        chk({tag, "_addr_out_of_range"}, n_addr_bad, 0);
        chk({tag, "_addr_steps"}, addr_seq.size(), n);
        for (int i = 0; i < addr_seq.size(); i++)
            if (int'(addr_seq[i]) != int'(f) + i) step_bad++;
        chk({tag, "_addr_seq_bad"}, step_bad, 0);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        check_rx(tag, 1'b1);
        @(posedge clock); #1;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int bad, n, len;
        logic [15:0] f;

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0010] = 32'h44332211;
        mem[16'h0000] = 32'hA5A5A5A5;
        mem[16'h0001] = 32'h00000000;
        mem[16'h0002] = 32'hFFFFFFFF;

        // Reset, with start held to show reset wins.
        first_addr = 16'h0003; last_addr = 16'h0007; start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_uart_tx", uart_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_range_err", range_err, 1'b0);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        start = 1'b0; rst = 1'b0;
        @(posedge clock); #1;
        chk("idle_busy", busy, 1'b0);

        // Single word, known bytes.
        flush_rx();
        run_dump(16'h0010, 16'h0010, 1'b0);
        dump_checks("one_word", 16'h0010, 16'h0010);

        // Three words with all-ones / all-zeros / alternating data.
        flush_rx();
        run_dump(16'h0000, 16'h0002, 1'b0);
        dump_checks("three_words", 16'h0000, 16'h0002);

        // Reversed range is refused.
        first_addr = 16'h0005; last_addr = 16'h0004; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("range_err_pulse", range_err, 1'b1);
        chk("range_err_busy", busy, 1'b0);
        chk("range_err_mem_addr", mem_addr, 16'h0002);
        bad = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (range_err !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1 || mem_addr !== 16'h0002) bad++;
        end
        chk("range_err_quiet", bad, 0);

        // Top of the address space: no wrap.
        flush_rx();
        run_dump(16'hFFFF, 16'hFFFF, 1'b0);
        dump_checks("addr_ffff", 16'hFFFF, 16'hFFFF);

        // Random short ranges with scrambled inputs while busy.
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(0, 2);
            f = 16'($urandom_range(0, 65533));
            flush_rx();
            run_dump(f, f + 16'(len), 1'b0);
            dump_checks($sformatf("rand%0d", it), f, f + 16'(len));
        end

        // Reset in the middle of the third frame.
        flush_rx();
        first_addr = 16'h0020; last_addr = 16'h0021; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (rx_t.size() < 3 && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("abort_reached_frame2", rx_t.size(), 3);
        repeat (10) begin @(posedge clock); #1; end
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        chk("abort_uart_tx", uart_tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_mem_addr", mem_addr, 16'h0000);
        bad = 0;
        repeat (60) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1) bad++;
        end
        chk("abort_quiet", bad, 0);
        chk("abort_complete_frames", rx_q.size(), 2);
        flush_rx();
        run_dump(16'h0030, 16'h0031, 1'b0);
        dump_checks("after_abort", 16'h0030, 16'h0031);

        // start held high: the next dump is accepted in the done cycle.
        flush_rx();
        run_dump(16'h0040, 16'h0040, 1'b1);
        chk("hold_first_cycles", n_cyc, WORD_CYC + 1);
        chk("hold_busy_at_done", busy, 1'b0);
        @(posedge clock); #1;
        chk("hold_restart_busy", busy, 1'b1);
        chk("hold_restart_addr", mem_addr, 16'h0040);
        start = 1'b0;
        first_addr = 16'h1234; last_addr = 16'h5678;
        n = 1;
        while (done !== 1'b1 && n < 20000) begin
            @(posedge clock); #1;
            n++;
            if (n % 7 == 0) start = ~start;
        end
        start = 1'b0;
        chk("hold_second_cycles", n, WORD_CYC + 1);
        build_exp(16'h0040, 16'h0040);
        check_rx("hold", 1'b0);
        @(posedge clock); #1;
        chk("hold_idle_after", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16; clock cycles per UART bit, legal range 2..1023.
REQ-002 Parameter: LANES, default 4; number of 8-bit lanes in one data-memory word.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006 first_addr  input  16  first word address to dump; sampled on the accepted start.
REQ-007 last_addr  input  16  last word address to dump, inclusive; sampled on the accepted start.
REQ-008 mem_addr  output  16  read address to the shared data memory (registered).
REQ-009 mem_q  input  8*LANES  read data from the data memory; lane k is bits [8k+7:8k].
REQ-010 uart_tx  output  1  serial output, 8N1, LSB first, idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a dump completes.
REQ-013 range_err  output  1  one-cycle pulse when a start is rejected because last_addr < first_addr.

Function
REQ-014 FSM states SHALL be IDLE, RD_ADDR, RD_WAIT, START_BIT, DATA_BITS, STOP_BIT, NEXT.
REQ-015 IDLE: start=1 with last_addr >= first_addr -> latch both addresses, mem_addr <= first_addr, go to RD_ADDR.
REQ-016 IDLE: start=1 with last_addr < first_addr -> range_err=1 for the next cycle, stay in IDLE; no memory read, uart_tx stays 1.
REQ-017 RD_ADDR -> RD_WAIT unconditionally; mem_addr is held stable from RD_ADDR through the end of the word.
REQ-018 RD_WAIT: capture mem_q into an 8*LANES word register on the edge leaving RD_WAIT (two edges after the mem_addr update); lane index <= 0; go to START_BIT.
REQ-019 START_BIT: uart_tx=0 for exactly CLKS_PER_BIT cycles, then DATA_BITS.
REQ-020 DATA_BITS: uart_tx drives bit i (i=0..7) of the current lane for CLKS_PER_BIT cycles each, then STOP_BIT.
REQ-021 STOP_BIT: uart_tx=1 for CLKS_PER_BIT cycles; afterwards, lane < LANES-1 -> lane+1, START_BIT; else NEXT.
REQ-022 Lanes SHALL be transmitted in order lane 0, lane 1, ... lane LANES-1; frames are back-to-back with no extra idle bits.
REQ-023 NEXT: mem_addr == latched last_addr -> IDLE with done=1 in the first IDLE cycle; else mem_addr+1, go to RD_ADDR.
REQ-024 Comparison precedes increment: last_addr = 0xFFFF SHALL terminate after address 0xFFFF with no wrap to 0x0000.
REQ-025 first_addr == last_addr SHALL dump exactly one word (LANES frames).
REQ-026 start while busy SHALL be ignored; first_addr/last_addr changes while busy SHALL have no effect.
REQ-027 A start in the same cycle as done (first IDLE cycle) SHALL be accepted.
REQ-028 Bit timing counter SHALL be 10 bits wide and reload to 0 at every bit boundary; no cumulative drift.
REQ-029 Total cycles from accepted start to done SHALL be N*(2 + LANES*10*CLKS_PER_BIT + 1) + 1, N = last_addr-first_addr+1.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state IDLE, uart_tx=1, busy=0, done=0, range_err=0, mem_addr=0x0000, lane index and bit counters 0.
REQ-031 rst asserted mid-frame SHALL abort immediately with no stop bit completed and no done pulse; rst has priority over start.

Verification
REQ-032 CLKS_PER_BIT=4, first=last=0x0010, mem[0x0010]=0x44332211 -> mem_addr=0x0010, frames 0x11,0x22,0x33,0x44 LSB first, 40 cycles each, done after 164 cycles.
REQ-033 first=0x0000, last=0x0002, words 0xA5A5A5A5/0x00000000/0xFFFFFFFF -> 12 frames, mem_addr steps 0,1,2, single done pulse, busy low only after last stop bit.
REQ-034 first=0x0005, last=0x0004 -> range_err pulse one cycle, busy stays 0, uart_tx constant 1, mem_addr unchanged.
REQ-035 first=last=0xFFFF -> exactly 4 frames, then done; mem_addr never becomes 0x0000 during the dump.
REQ-036 rst pulsed during DATA_BITS of frame 2 -> next cycle uart_tx=1, busy=0, no done; new start afterwards dumps from the new first_addr correctly.
REQ-037 start held high continuously through a dump -> second dump begins in the done cycle; start pulses while busy produce no extra frames.
